// File: rtl/latch_bank_wr_arb.sv
// Round-robin write arbiter/sequencer for a bank of level-sensitive D latches.
// Latency: grant edge to ack = SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles; one IDLE cycle between grants.
// Backpressure: requesters hold req until their one-cycle ack; losers simply wait.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req               per-requester write request (level)
//   req_addr/req_data per-requester address/data, requester i at [i*W +: W]
//   ack               one-cycle completion pulse to the granted requester
//   lat_d, lat_en     shared data bus and one-hot enables to the latch bank
//   busy              high whenever the sequencer is not IDLE
//   lat_q, wr_err     only with LATCH_WR_VERIFY_EN: latch readback and sticky
//                     write-verify error
module latch_bank_wr_arb #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 2,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef LATCH_WR_VERIFY_EN
  input  logic [DEPTH*DATA_W-1:0]   lat_q,
  output logic                      wr_err,
`endif
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         lat_d,
  output logic [DEPTH-1:0]          lat_en,
  output logic                      busy
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAXC_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAXC   = (MAXC_A > HOLD_CYC) ? MAXC_A : HOLD_CYC;
  localparam int CNT_W  = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   cap_idx;
  logic [ADDR_W-1:0]  cap_addr;
  logic [DATA_W-1:0]  cap_data;

  logic               any_req;
  logic [IDX_W-1:0]   win_idx;
  logic [DEPTH-1:0]   en_onehot;
  int                 scan;

  // First set request at or above rr_ptr, wrapping.
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    scan    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = int'(rr_ptr) + i;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      if (!any_req && req[scan]) begin
        any_req = 1'b1;
        win_idx = IDX_W'(scan);
      end
    end
  end

  // Out-of-range addresses decode to no enable at all.
  always_comb begin
    en_onehot = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (int'(cap_addr) == j) en_onehot[j] = 1'b1;
    end
  end

  // Outputs are registered from the current state, so each output phase
  // trails the state by one edge but keeps the state's exact duration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rr_ptr   <= '0;
      cap_idx  <= '0;
      cap_addr <= '0;
      cap_data <= '0;
      ack      <= '0;
      lat_d    <= '0;
      lat_en   <= '0;
      busy     <= 1'b0;
`ifdef LATCH_WR_VERIFY_EN
      wr_err   <= 1'b0;
`endif
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          lat_en <= '0;
          if (any_req) begin
            cap_idx  <= win_idx;
            cap_addr <= req_addr[win_idx*ADDR_W +: ADDR_W];
            cap_data <= req_data[win_idx*DATA_W +: DATA_W];
            cnt      <= '0;
            state    <= SETUP;
            busy     <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        SETUP: begin
          lat_d  <= cap_data;
          lat_en <= '0;
          if (cnt == CNT_W'(SETUP_CYC - 1)) begin
            cnt   <= '0;
            state <= PULSE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PULSE: begin
          lat_en <= en_onehot;
          if (cnt == CNT_W'(PULSE_CYC - 1)) begin
            cnt   <= '0;
            state <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          lat_en <= '0;
          if (cnt == CNT_W'(HOLD_CYC - 1)) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          ack    <= NUM_REQ'(1) << cap_idx;
          rr_ptr <= (cap_idx == IDX_W'(NUM_REQ - 1)) ? '0 : cap_idx + 1'b1;
          state  <= IDLE;
          busy   <= 1'b0;
`ifdef LATCH_WR_VERIFY_EN
          if ((int'(cap_addr) < DEPTH) &&
              (lat_q[int'(cap_addr)*DATA_W +: DATA_W] != cap_data))
            wr_err <= 1'b1;
`endif
        end
        default: begin
          state  <= IDLE;
          lat_en <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_bank_wr_arb.sv
// Self-checking bench for latch_bank_wr_arb: default 4x4 instance plus a
// DEPTH=3 instance for out-of-range addressing.
// Build with LATCH_WR_VERIFY_EN defined to also exercise the verify path.
module tb_latch_bank_wr_arb;

  logic        clk;
  logic        rst_n;

  logic [3:0]  req4;
  logic [7:0]  req_addr4;
  logic [31:0] req_data4;
  logic [3:0]  ack4;
  logic [7:0]  lat_d4;
  logic [3:0]  lat_en4;
  logic        busy4;
  logic [31:0] lat_q4;
  logic        wr_err4;

  logic [1:0]  req3;
  logic [3:0]  req_addr3;
  logic [15:0] req_data3;
  logic [1:0]  ack3;
  logic [7:0]  lat_d3;
  logic [2:0]  lat_en3;
  logic        busy3;
  logic [23:0] lat_q3;
  logic        wr_err3;

  int checks   = 0;
  int failures = 0;
  int sb[$];

  logic [7:0] mem4 [4];
  logic [7:0] mem3 [3];
  logic       corrupt = 1'b0;

  latch_bank_wr_arb u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .req_addr(req_addr4), .req_data(req_data4),
`ifdef LATCH_WR_VERIFY_EN
    .lat_q(lat_q4), .wr_err(wr_err4),
`endif
    .ack(ack4), .lat_d(lat_d4), .lat_en(lat_en4), .busy(busy4)
  );

  latch_bank_wr_arb #(.NUM_REQ(2), .DEPTH(3), .ADDR_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .req_addr(req_addr3), .req_data(req_data3),
`ifdef LATCH_WR_VERIFY_EN
    .lat_q(lat_q3), .wr_err(wr_err3),
`endif
    .ack(ack3), .lat_d(lat_d3), .lat_en(lat_en3), .busy(busy3)
  );

`ifndef LATCH_WR_VERIFY_EN
  assign wr_err4 = 1'b0;
  assign wr_err3 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Behavioural latch bank; corrupt pins word 0 of the 4-word bank to zero.
  initial begin
    for (int i = 0; i < 4; i++) mem4[i] = '0;
    for (int i = 0; i < 3; i++) mem3[i] = '0;
  end
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (lat_en4[i]) mem4[i] = lat_d4;
    for (int i = 0; i < 3; i++) if (lat_en3[i]) mem3[i] = lat_d3;
    if (corrupt) mem4[0] = 8'h00;
  end
  assign lat_q4 = {mem4[3], mem4[2], mem4[1], mem4[0]};
  assign lat_q3 = {mem3[2], mem3[1], mem3[0]};

  // Scoreboard and bus-protocol monitor for the 4-requester instance.
  int         run_len = 0;
  logic [7:0] prev_d  = '0;
  logic [3:0] prev_en = '0;
  always @(negedge clk) begin
    if (ack4 != 4'b0) begin
      if (sb.size() == 0) chk("ack_unexpected", 32'(ack4), 32'h0);
      else chk("ack_order", 32'(ack4), 32'd1 << sb.pop_front());
    end
    if (!rst_n) begin
      run_len = 0;
    end else begin
      if (lat_en4 != 4'b0) run_len++;
      else if (run_len != 0) begin
        chk("pulse_width", run_len, 2);
        run_len = 0;
      end
      if (lat_d4 != prev_d) chk("d_change_en_low", 32'(prev_en | lat_en4), 32'h0);
    end
    prev_d  = lat_d4;
    prev_en = lat_en4;
  end

  task automatic run3(input logic [1:0] addr, input logic [7:0] data, input logic [2:0] exp_en);
    @(negedge clk);
    req_addr3[1:0] = addr;
    req_data3[7:0] = data;
    req3 = 2'b01;
    @(negedge clk);
    for (int m = 1; m <= 5; m++) begin
      @(negedge clk);
      if (m == 2 || m == 3) chk("r3_en_pulse", 32'(lat_en3), 32'(exp_en));
      else chk("r3_en_low", 32'(lat_en3), 32'h0);
      if (m == 5) begin
        chk("r3_ack", 32'(ack3), 32'h1);
        req3 = 2'b00;
      end else begin
        chk("r3_no_ack", 32'(ack3), 32'h0);
      end
    end
    chk("r3_lat_d", 32'(lat_d3), 32'(data));
  endtask

  int nack;
  int last_ack_cyc;
  int cyc;
  logic seen;

  initial begin
    rst_n = 1'b0;
    req4 = 4'($urandom);
    req_addr4 = 8'($urandom);
    req_data4 = $urandom;
    req3 = '0; req_addr3 = '0; req_data3 = '0;

    // Reset with random requests.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ack", 32'(ack4), 32'h0);
      chk("rst_en", 32'(lat_en4), 32'h0);
      chk("rst_d", 32'(lat_d4), 32'h0);
      chk("rst_busy", 32'(busy4), 32'h0);
      req4 = 4'($urandom);
    end
    req4 = 4'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy4), 32'h0);
    chk("idle_en", 32'(lat_en4), 32'h0);

    // Single write from requester 2; data change after grant must be ignored.
    req_addr4 = 8'h00; req_data4 = '0;
    req_addr4[5:4] = 2'd1;
    req_data4[23:16] = 8'hA5;
    req4 = 4'b0100;
    sb.push_back(2);
    @(negedge clk);
    chk("wr_busy_k", 32'(busy4), 32'h1);
    chk("wr_d_k", 32'(lat_d4), 32'h0);
    req_data4[23:16] = 8'h5A;
    req_addr4[5:4] = 2'd3;
    for (int m = 1; m <= 5; m++) begin
      @(negedge clk);
      chk("wr_d", 32'(lat_d4), 32'hA5);
      if (m == 2 || m == 3) chk("wr_en_pulse", 32'(lat_en4), 32'h2);
      else chk("wr_en_low", 32'(lat_en4), 32'h0);
      if (m == 5) begin
        chk("wr_ack", 32'(ack4), 32'h4);
        req4 = 4'b0;
      end
    end
    @(negedge clk);
    chk("wr_d_idle", 32'(lat_d4), 32'hA5);

    // Contention from reset: all requesters held.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr4[i*2 +: 2] = 2'(i);
      req_data4[i*8 +: 8] = 8'h10 + 8'(i);
    end
    req4 = 4'b1111;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3); sb.push_back(0);
    nack = 0;
    last_ack_cyc = 0;
    for (cyc = 0; cyc < 200 && nack < 5; cyc++) begin
      @(negedge clk);
      if (ack4 != 4'b0) begin
        if (nack > 0) chk("ack_spacing", cyc - last_ack_cyc, 6);
        last_ack_cyc = cyc;
        nack++;
      end
    end
    req4 = 4'b0;
    chk("contention_acks", nack, 5);

`ifdef LATCH_WR_VERIFY_EN
    // Verify: word 0 reads back wrong; rr pointer is 1 so requester 0 wins on wrap.
    @(negedge clk);
    chk("ver_err_clean", 32'(wr_err4), 32'h0);
    corrupt = 1'b1;
    req_addr4[1:0] = 2'd0;
    req_data4[7:0] = 8'hFF;
    req4 = 4'b0001;
    sb.push_back(0);
    @(negedge clk);
    for (int m = 1; m <= 5; m++) begin
      @(negedge clk);
      if (m == 4) chk("ver_err_pre", 32'(wr_err4), 32'h0);
      if (m == 5) begin
        chk("ver_err_done", 32'(wr_err4), 32'h1);
        req4 = 4'b0;
      end
    end
    corrupt = 1'b0;
    repeat (3) @(negedge clk);
    chk("ver_err_sticky", 32'(wr_err4), 32'h1);
`endif

    // Abort during PULSE; rr pointer must return to 0.
    @(negedge clk);
    req_addr4[7:6] = 2'd3;
    req_data4[31:24] = 8'h77;
    req4 = 4'b1000;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (lat_en4 != 4'b0) seen = 1'b1;
    end
    chk("abort_reached_pulse", 32'(seen), 32'h1);
    #3 rst_n = 1'b0;
    req4 = 4'b1001;
    #1;
    chk("abort_en", 32'(lat_en4), 32'h0);
    chk("abort_busy", 32'(busy4), 32'h0);
    chk("abort_err", 32'(wr_err4), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ack4 != 4'b0) begin
        seen = 1'b1;
        chk("abort_rr_reset", 32'(ack4), 32'h1);
        req4 = 4'b0;
      end
    end
    chk("abort_ack_seen", 32'(seen), 32'h1);
    req4 = 4'b0;

    // DEPTH=3 instance: out-of-range address, then in-range top word.
    run3(2'b11, 8'h3C, 3'b000);
    chk("oor_err", 32'(wr_err3), 32'h0);
    run3(2'b10, 8'hC3, 3'b100);
    chk("inr_err", 32'(wr_err3), 32'h0);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
